// File: rtl/calc_op_sequencer_if.sv
// Request/response bundle between the calculator FSM and the arithmetic sequencer.
// master issues start/op/a/b; slave answers with ready/done/result/ovf/dbz.
interface calc_op_sequencer_if #(
   parameter int WIDTH = 16
);
   logic                    start;
   logic [1:0]              op;
   logic signed [WIDTH-1:0] a;
   logic signed [WIDTH-1:0] b;
   logic                    ready;
   logic                    done;
   logic signed [WIDTH-1:0] result;
   logic                    ovf;
   logic                    dbz;

   modport master (output start, op, a, b, input ready, done, result, ovf, dbz);
   modport slave  (input start, op, a, b, output ready, done, result, ovf, dbz);
endinterface

// File: rtl/calc_op_sequencer.sv
// Fixed-point add/sub/mul/div sequencer with a shared shift-add / restoring-divide datapath.
// Latency: add/sub/dbz 2, div 34, mul 50 cycles; requests are ignored (not queued) while ready is low.
module calc_op_sequencer #(
   parameter int WIDTH = 16,
   parameter int SCALE = 100
) (
   input  logic                clk,
   input  logic                rst,
   calc_op_sequencer_if.slave  bus
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(PW);
   localparam logic signed [PW+1:0] SAT_MAX = $signed({{(PW+3-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}});
   localparam logic signed [PW+1:0] SAT_MIN = $signed({{(PW+3-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}});

   typedef enum logic [2:0] {IDLE, PREP, MUL, DIV, FIN, DONE} state_t;
   state_t state, state_n;

   logic [1:0]              op_r;
   logic signed [WIDTH-1:0] a_r, b_r;
   logic                    neg, dbz_pend;
   logic [WIDTH:0]          sum_r, mag_a, mag_b;
   logic [PW-1:0]           acc, dvd, dsr, rem;
   logic [CW-1:0]           cnt;
   logic [WIDTH-1:0]        result_r;
   logic                    ovf_r, dbz_r;
   logic                    ready_c, done_c;

   logic [WIDTH:0]          a_ext, b_ext, mag_a_c, mag_b_c;
   logic [PW-1:0]           acc_n, rem_n;
   logic [PW:0]             rem_sh;
   logic                    div_ge;
   logic signed [PW+1:0]    fin_val;
   logic [WIDTH-1:0]        res_c;
   logic                    ovf_c;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      ready_c = 1'b0;
      done_c  = 1'b0;
      case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.start) state_n = PREP;
         end
         PREP: begin
            case (op_r)
               2'b10:   state_n = MUL;
               2'b11:   state_n = (b_r == '0) ? FIN : DIV;
               default: state_n = FIN;
            endcase
         end
         MUL:  if (cnt == CW'(WIDTH - 1)) state_n = DIV;
         DIV:  if (cnt == CW'(PW - 1))    state_n = FIN;
         FIN:  state_n = DONE;
         DONE: begin
            done_c  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Magnitudes carry one extra bit so that |most-negative| stays positive.
   always_comb begin
      a_ext   = {a_r[WIDTH-1], a_r};
      b_ext   = {b_r[WIDTH-1], b_r};
      mag_a_c = a_ext[WIDTH] ? (~a_ext + (WIDTH+1)'(1)) : a_ext;
      mag_b_c = b_ext[WIDTH] ? (~b_ext + (WIDTH+1)'(1)) : b_ext;

      acc_n   = acc + (mag_b[cnt] ? (PW'(mag_a) << cnt) : '0);

      rem_sh  = {rem, dvd[PW-1]};
      div_ge  = (rem_sh >= {1'b0, dsr});
      rem_n   = div_ge ? PW'(rem_sh - {1'b0, dsr}) : rem_sh[PW-1:0];

      if (op_r[1]) fin_val = neg ? -$signed({2'b00, dvd}) : $signed({2'b00, dvd});
      else         fin_val = (PW+2)'($signed(sum_r));

      ovf_c = 1'b0;
      res_c = fin_val[WIDTH-1:0];
      if (fin_val > SAT_MAX) begin
         res_c = {1'b0, {(WIDTH-1){1'b1}}};
         ovf_c = 1'b1;
      end else if (fin_val < SAT_MIN) begin
         res_c = {1'b1, {(WIDTH-1){1'b0}}};
         ovf_c = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         neg      <= 1'b0;
         dbz_pend <= 1'b0;
         sum_r    <= '0;
         mag_a    <= '0;
         mag_b    <= '0;
         acc      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         rem      <= '0;
         cnt      <= '0;
         result_r <= '0;
         ovf_r    <= 1'b0;
         dbz_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_r     <= bus.op;
                  a_r      <= bus.a;
                  b_r      <= bus.b;
                  ovf_r    <= 1'b0;
                  dbz_r    <= 1'b0;
                  dbz_pend <= 1'b0;
               end
            end
            PREP: begin
               mag_a <= mag_a_c;
               mag_b <= mag_b_c;
               neg   <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
               acc   <= '0;
               rem   <= '0;
               cnt   <= '0;
               case (op_r)
                  2'b00: sum_r <= a_ext + b_ext;
                  2'b01: sum_r <= a_ext - b_ext;
                  2'b11: begin
                     if (b_r == '0) begin
                        dbz_pend <= 1'b1;
                     end else begin
                        dvd <= PW'(mag_a_c) * PW'(SCALE);
                        dsr <= PW'(mag_b_c);
                     end
                  end
                  default: ;
               endcase
            end
            MUL: begin
               acc <= acc_n;
               cnt <= cnt + CW'(1);
               // The product always goes back through the divider to remove one SCALE.
               if (cnt == CW'(WIDTH - 1)) begin
                  dvd <= acc_n;
                  dsr <= PW'(SCALE);
                  rem <= '0;
                  cnt <= '0;
               end
            end
            DIV: begin
               dvd <= {dvd[PW-2:0], div_ge};
               rem <= rem_n;
               cnt <= cnt + CW'(1);
            end
            FIN: begin
               if (dbz_pend) begin
                  result_r <= '0;
                  ovf_r    <= 1'b0;
                  dbz_r    <= 1'b1;
               end else begin
                  result_r <= res_c;
                  ovf_r    <= ovf_c;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready  = ready_c;
   assign bus.done   = done_c;
   assign bus.result = result_r;
   assign bus.ovf    = ovf_r;
   assign bus.dbz    = dbz_r;
endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Multi-cycle arithmetic sequencer for the fixed-point calculator. It accepts one operation at a time (add, sub, mul, div) on two signed decimal fixed-point operands, and runs mul/div through a single shared shift-add / restoring-divide datapath. It returns a saturated result with status flags. It sits between the calculator FSM (which collects button digits/operators) and the 7-segment formatting stage, replacing single-cycle `*` and `/` arithmetic.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width. Values are signed two's complement, real value × `SCALE`.
- `SCALE`, 100, fixed-point scale: two decimal fractional digits, so 5.25 is encoded as 525.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Accepted only on an edge where `start & ready`.
- `op`  in  2  operation: 00 add, 01 sub, 10 mul, 11 div. Sampled at accept.
- `a`  in  WIDTH  signed left operand. Sampled at accept.
- `b`  in  WIDTH  signed right operand. Sampled at accept.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle pulse; result and flags are valid.
- `result`  out  WIDTH  signed result, held until the next accept.
- `ovf`  out  1  result saturated. Held with `result`.
- `dbz`  out  1  divide by zero. Held with `result`.

## Operation
- States: IDLE, PREP, MUL, DIV, FIN, DONE.
- IDLE to PREP on accept. At accept, register `op`, `a` and `b`, and clear `ovf` and `dbz`.
- PREP:
  - Form the 17-bit magnitudes |a| and |b|. |−32768| must be representable.
  - Record `neg = sign(a) XOR sign(b)`.
  - add/sub: compute the 17-bit signed sum/difference, then go to FIN.
  - mul: go to MUL.
  - div with b==0: set `dbz`, then go to FIN.
  - div otherwise: load the 32-bit dividend as |a|×SCALE and the divisor as |b|, then go to DIV.
- MUL: 16 iterations of shift-add over bits of |b|, one bit per cycle, into a 32-bit accumulator. Then load dividend = product and divisor = SCALE, and go to DIV.
- DIV: 32 iterations of restoring division, one quotient bit per cycle, truncating toward zero. Then go to FIN.
- FIN:
  - Apply `neg` to the quotient magnitude (mul/div) or take the add/sub sum as-is.
  - Saturate: a value > 2^(WIDTH−1)−1 gives 32767 with `ovf`=1; a value < −2^(WIDTH−1) gives −32768 with `ovf`=1.
  - `dbz` gives `result`=0, `ovf`=0.
  - Register `result`, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` while not `ready` is ignored. It is not queued.
- The divider datapath is shared: mul always ends with the ÷SCALE pass through DIV.
- Truncation is toward zero in both mul and div. For example, −1.50 × 2.25 = −3.375 yields −337.

## Timing
Accept edge = E0.
- add/sub, and div-by-zero: `done` high after edge E0+2.
- div: `done` high after E0+34 (PREP 1, DIV 32, FIN 1).
- mul: `done` high after E0+50 (PREP 1, MUL 16, DIV 32, FIN 1).
- `ready` is low from after E0 through the DONE cycle. It rises the cycle after `done`, so the next accept is at the earliest one cycle after `done`.
- `result`, `ovf` and `dbz` update only at the FIN→DONE edge. They are stable from `done` until the next accept clears the flags; `result` holds until the next FIN.
- Reset values: state IDLE, `ready`=1, `done`=0, `result`=0, `ovf`=0, `dbz`=0.
- `rst` mid-operation aborts immediately:
  - No `done` pulse is produced.
  - `result` is forced to 0.
  - `ready`=1 the cycle after the reset edge.
- `rst` and `start` on the same edge: reset wins and the request is dropped.

## Test plan
- Reset, then add with a=525, b=300: `done` after E0+2, `result`=825, `ovf`=0, `dbz`=0. Then sub with a=500, b=300: `result`=200.
- Div with a=600, b=300: `done` exactly after E0+34, `result`=200. Next, mul with a=200, b=800: `done` after E0+50, `result`=1600.
- Mul with a=−150, b=225: `result`=−337. Div with a=−100, b=300: `result`=−33, `ovf`=0.
- Saturation:
  - add with a=30000, b=10000: `result`=32767, `ovf`=1.
  - sub with a=−30000, b=10000: `result`=−32768, `ovf`=1.
  - mul with a=20000, b=20000: `result`=32767, `ovf`=1.
- Div with a=500, b=0: `done` after E0+2, `result`=0, `dbz`=1. The following add with a=100, b=100 shows `dbz`=0 and `result`=200.
- Busy and abort:
  - Assert `start` with new operands during a mul: the request is ignored and the original mul result is returned.
  - Assert `rst` at E0+20 of a div: no `done`, `result`=0, `ready`=1 after one cycle, and a subsequent add completes normally.
